mat_port_arbiter: RTL

MAT_PORT_ARBITER -- requirements
Module: mat_port_arbiter

---
 rtl/mat_pkg.sv | 30 +++
 rtl/mat_port_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mat_pkg.sv
// Shared constants and types for the matrix-multiplier datapath and its
// memory-port arbiter.
package mat_pkg;

  // Matrix geometry and element width
  localparam int MAT_DATA_W    = 16;
  localparam int MAT_DIM       = 10;
  localparam int MAT_IDX_W     = 4;

  // Accumulator wide enough for a full dot product of DIM products
  localparam int MAT_ACC_W     = 2 * MAT_DATA_W + $clog2(MAT_DIM);

  // Longest locked burst one requester may hold while the other waits
  localparam int MAT_MAX_BURST = 12;

  // Memory-port arbiter states
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  // True when both element indices fall inside a dim x dim matrix
  function automatic logic mat_idx_ok(input logic [MAT_IDX_W-1:0] row,
                                      input logic [MAT_IDX_W-1:0] col,
                                      input int                   dim);
    return (int'(row) < dim) && (int'(col) < dim);
  endfunction

endpackage

// File: rtl/mat_port_arbiter.sv
// Two-requester arbiter for the single matrix memory port.
// Requester 0 is the compute control path, requester 1 the host load/unload
// path. A granted requester issues one access per cycle; lock keeps the grant
// for a burst, bounded by MAX_BURST only while the other side is waiting.
// Read data returns one cycle after the memory sees the read and is steered
// to the requester that issued it, even if the grant has moved on.
module mat_port_arbiter
  import mat_pkg::*;
#(
  parameter int DATA_W    = MAT_DATA_W,
  parameter int DIM       = MAT_DIM,
  parameter int MAX_BURST = MAT_MAX_BURST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [3:0]        row0,
  input  logic [3:0]        col0,
  input  logic [3:0]        row1,
  input  logic [3:0]        col1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              addr_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_row,
  output logic [3:0]        mem_col,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                 BURST_W     = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_ONE   = BURST_W'(1);

  // Arbitration state
  arb_state_e         state_q, state_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] burst_inc;

  // Read-return tag pipeline
  logic               rd_pend_q, rd_pend_d;
  logic               rd_tag_q, rd_tag_d;
  logic               rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0]  rdata_q;

  // Current owner's request fields, selected by the grant
  logic               owned;
  logic               owner;
  logic               own_req;
  logic               own_lock;
  logic               own_we;
  logic [3:0]         own_row;
  logic [3:0]         own_col;
  logic [DATA_W-1:0]  own_wdata;
  logic               other_req;

  // An access is attempted whenever the owner requests; it only reaches the
  // memory when its address is inside the matrix and reset is low.
  logic               access;
  logic               addr_ok;
  logic               issue;

  // Select the request fields of whichever side currently holds the grant
  always_comb begin
    owned = (state_q == ARB_OWN0) || (state_q == ARB_OWN1);
    owner = (state_q == ARB_OWN1);
    if (owner) begin
      own_req   = req1;
      own_lock  = lock1;
      own_we    = we1;
      own_row   = row1;
      own_col   = col1;
      own_wdata = wdata1;
      other_req = req0;
    end else begin
      own_req   = req0;
      own_lock  = lock0;
      own_we    = we0;
      own_row   = row0;
      own_col   = col0;
      own_wdata = wdata0;
      other_req = req1;
    end
  end

  assign access  = owned && own_req;
  assign addr_ok = mat_idx_ok(own_row, own_col, DIM);
  assign issue   = access && addr_ok && !reset;

  // Burst length only advances while the other side is kept waiting, so an
  // uncontested lock never runs into the limit. Suppressed (bad-address)
  // accesses still count: grant handling treats them as issued.
  assign burst_inc = (access && other_req) ? (burst_q + BURST_ONE) : burst_q;

  // State register: grant owner, round-robin pointer and burst length
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= 1'b0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
    end
  end

  // Next-state logic: pick a winner from IDLE, keep or hand over the grant
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    case (state_q)
      ARB_IDLE: begin
        if (req0 && req1) begin
          state_d = rr_ptr_q ? ARB_OWN1 : ARB_OWN0;
        end else if (req0) begin
          state_d = ARB_OWN0;
        end else if (req1) begin
          state_d = ARB_OWN1;
        end
      end
      ARB_OWN0, ARB_OWN1: begin
        // The limit is checked against the count including this access so
        // that exactly MAX_BURST contested accesses fit in one burst.
        if (own_req && own_lock && (burst_inc < BURST_LIMIT)) begin
          burst_d = burst_inc;
        end else begin
          rr_ptr_d = ~owner;
          if (other_req) begin
            state_d = owner ? ARB_OWN0 : ARB_OWN1;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    // Every change of grant starts a fresh burst
    if (state_d != state_q) begin
      burst_d = '0;
    end
  end

  // Output logic: grants from state, memory port driven only by a live access
  always_comb begin
    gnt0      = (state_q == ARB_OWN0);
    gnt1      = (state_q == ARB_OWN1);
    mem_en    = issue;
    mem_we    = issue && own_we;
    mem_row   = issue ? own_row   : '0;
    mem_col   = issue ? own_col   : '0;
    mem_wdata = issue ? own_wdata : '0;
    addr_err  = access && !addr_ok && !reset;
  end

  // A read launched this cycle is remembered with its requester's id
  assign rd_pend_d = issue && !own_we;
  assign rd_tag_d  = owner;

  // Read return: memory data arrives one cycle after the read and is
  // captured together with the valid for the tagged requester
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      rd_tag_q  <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
      rvalid0_q <= rd_pend_q && !rd_tag_q;
      rvalid1_q <= rd_pend_q && rd_tag_q;
      if (rd_pend_q) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = rdata_q;

endmodule
